// File: rtl/assoc_btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//   - entry_t   : logical content of one BTB entry (widest supported PC)
//   - state_t   : sweep controller states
//   - pc_index / pc_tag / pc_target : PC field extraction. PCs are passed
//     zero-extended to MAX_AW bits; callers size-cast the result to their
//     own ADDR_WIDTH / SET_NUM derived field widths.
//   - ctr_next  : 2-bit saturating direction counter step
package assoc_btb_pkg;

  localparam int MAX_AW = 64;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] tag;
    logic [MAX_AW-3:0] target;
    logic [1:0]        ctr;
  } entry_t;

  function automatic logic [MAX_AW-1:0] pc_index(input logic [MAX_AW-1:0] pc,
                                                 input int set_num);
    return (pc >> 2) & MAX_AW'(set_num - 1);
  endfunction

  function automatic logic [MAX_AW-1:0] pc_tag(input logic [MAX_AW-1:0] pc,
                                               input int addr_width,
                                               input int set_num);
    logic [MAX_AW-1:0] mask;
    mask = '1;
    mask = mask >> (MAX_AW - addr_width);
    return (pc & mask) >> (2 + $clog2(set_num));
  endfunction

  function automatic logic [MAX_AW-1:0] pc_target(input logic [MAX_AW-1:0] pc);
    return pc >> 2;
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'd3) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/assoc_btb_ram.sv
// Block RAM holding {tag, target, counter} for one BTB way.
// One write port and two independent registered read ports (lookup and
// update read-modify-write). Reads return the contents from before a
// same-edge write.
//   clk               : clock
//   we/waddr/wdata    : write port
//   raddr_a/rdata_a   : read port A (registered)
//   raddr_b/rdata_b   : read port B (registered)
module assoc_btb_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_a <= mem_q[raddr_a];
    rdata_b <= mem_q[raddr_b];
  end

endmodule

// File: rtl/assoc_btb.sv
// Set-associative branch target buffer with 1-cycle lookup, round-robin
// replacement and a set-per-cycle invalidation sweep.
//   clk, rst (sync, active high), flush (invalidate-all pulse)
//   ready          : not sweeping
//   rdPc           : lookup PC; btbHit/btbPredictedPc answer one edge later
//   updValid/updPc/updTaken/updTarget : resolved branch update
//
// state    | meaning
// ST_IDLE  | lookups and updates serviced
// ST_CLEAR | clearing valid bits / victim pointer of set set_cnt_q
//
// Updates are a 2-stage read-modify-write: the set is read from RAM at the
// accepting edge and written one edge later. The write just performed is
// held in lw_* and forwarded to any RAM read that sampled the same edge.
module assoc_btb #(
  parameter int ADDR_WIDTH = 32,
  parameter int SET_NUM    = 64,
  parameter int WAY_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] rdPc,
  output logic                  btbHit,
  output logic [ADDR_WIDTH-1:0] btbPredictedPc,
  input  logic                  updValid,
  input  logic [ADDR_WIDTH-1:0] updPc,
  input  logic                  updTaken,
  input  logic [ADDR_WIDTH-1:0] updTarget
);
  import assoc_btb_pkg::*;

  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int TAG_W  = ADDR_WIDTH - 2 - IDX_W;
  localparam int TGT_W  = ADDR_WIDTH - 2;
  localparam int DATA_W = TAG_W + TGT_W + 2;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       set_cnt_q, set_cnt_d;
  logic [WAY_NUM-1:0]     valid_q [SET_NUM];
  logic [WAY_NUM-1:0]     valid_d [SET_NUM];
  logic [WAY_W-1:0]       vptr_q [SET_NUM];
  logic [WAY_W-1:0]       vptr_d [SET_NUM];

  logic                   rdy_s_q, rdy_s_d;
  logic [IDX_W-1:0]       rd_idx_s_q, rd_idx_s_d;
  logic [TAG_W-1:0]       tag_s_q, tag_s_d;
  logic [WAY_NUM-1:0]     vld_s_q, vld_s_d;

  logic                   u_vld_q, u_vld_d;
  logic [IDX_W-1:0]       u_idx_q, u_idx_d;
  logic [TAG_W-1:0]       u_tag_q, u_tag_d;
  logic                   u_taken_q, u_taken_d;
  logic [TGT_W-1:0]       u_tgt_q, u_tgt_d;

  logic                   lw_vld_q, lw_vld_d;
  logic [IDX_W-1:0]       lw_idx_q, lw_idx_d;
  logic [WAY_W-1:0]       lw_way_q, lw_way_d;
  logic [DATA_W-1:0]      lw_data_q, lw_data_d;

  logic [IDX_W-1:0]       rd_idx;
  logic [DATA_W-1:0]      lk_rdata [WAY_NUM];
  logic [DATA_W-1:0]      up_rdata [WAY_NUM];
  logic [DATA_W-1:0]      lk_ent, hit_ent;
  logic [DATA_W-1:0]      u_ent [WAY_NUM];
  logic                   lk_fwd, u_fwd;
  logic                   u_hit, u_inv;
  logic [WAY_W-1:0]       u_hit_way, u_inv_way;

  assign rd_idx = IDX_W'(pc_index(MAX_AW'(rdPc), SET_NUM));
  assign ready  = (state_q == ST_IDLE);

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    assoc_btb_ram #(.DATA_W(DATA_W), .DEPTH(SET_NUM), .IDX_W(IDX_W)) u_ram (
      .clk     (clk),
      .we      (lw_vld_d && (lw_way_d == WAY_W'(w))),
      .waddr   (lw_idx_d),
      .wdata   (lw_data_d),
      .raddr_a (rd_idx),
      .rdata_a (lk_rdata[w]),
      .raddr_b (u_idx_d),
      .rdata_b (up_rdata[w])
    );
  end

  // Lookup answer from the snapshot taken at the last edge.
  always_comb begin
    btbHit         = 1'b0;
    btbPredictedPc = '0;
    lk_fwd         = 1'b0;
    lk_ent         = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      lk_fwd = lw_vld_q && (lw_idx_q == rd_idx_s_q) && (lw_way_q == WAY_W'(w));
      lk_ent = lk_fwd ? lw_data_q : lk_rdata[w];
      if (rdy_s_q && (vld_s_q[w] || lk_fwd) &&
          (lk_ent[DATA_W-1 -: TAG_W] == tag_s_q) && lk_ent[1]) begin
        btbHit         = 1'b1;
        btbPredictedPc = {lk_ent[2 +: TGT_W], 2'b00};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    valid_d    = valid_q;
    vptr_d     = vptr_q;

    rdy_s_d    = (state_q == ST_IDLE);
    rd_idx_s_d = rd_idx;
    tag_s_d    = TAG_W'(pc_tag(MAX_AW'(rdPc), ADDR_WIDTH, SET_NUM));
    vld_s_d    = valid_q[rd_idx];

    u_vld_d    = updValid && (state_q == ST_IDLE) && !flush;
    u_idx_d    = IDX_W'(pc_index(MAX_AW'(updPc), SET_NUM));
    u_tag_d    = TAG_W'(pc_tag(MAX_AW'(updPc), ADDR_WIDTH, SET_NUM));
    u_taken_d  = updTaken;
    u_tgt_d    = TGT_W'(pc_target(MAX_AW'(updTarget)));

    lw_vld_d   = 1'b0;
    lw_idx_d   = u_idx_q;
    lw_way_d   = '0;
    lw_data_d  = '0;

    u_fwd      = 1'b0;
    u_hit      = 1'b0;
    u_hit_way  = '0;
    u_inv      = 1'b0;
    u_inv_way  = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      u_fwd    = lw_vld_q && (lw_idx_q == u_idx_q) && (lw_way_q == WAY_W'(w));
      u_ent[w] = u_fwd ? lw_data_q : up_rdata[w];
      if (valid_q[u_idx_q][w] && (u_ent[w][DATA_W-1 -: TAG_W] == u_tag_q)) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_W'(w);
      end
      if (!valid_q[u_idx_q][w] && !u_inv) begin
        u_inv     = 1'b1;
        u_inv_way = WAY_W'(w);
      end
    end
    hit_ent = u_ent[u_hit_way];

    if (u_vld_q) begin
      if (u_hit) begin
        lw_vld_d  = 1'b1;
        lw_way_d  = u_hit_way;
        lw_data_d = {hit_ent[DATA_W-1 -: TAG_W],
                     u_taken_q ? u_tgt_q : hit_ent[2 +: TGT_W],
                     ctr_next(hit_ent[1:0], u_taken_q)};
      end else if (u_taken_q) begin
        lw_vld_d  = 1'b1;
        lw_way_d  = u_inv ? u_inv_way : vptr_q[u_idx_q];
        lw_data_d = {u_tag_q, u_tgt_q, 2'd2};
        valid_d[u_idx_q][lw_way_d] = 1'b1;
        if (!u_inv) begin
          vptr_d[u_idx_q] = (vptr_q[u_idx_q] == WAY_W'(WAY_NUM - 1)) ? '0
                          : vptr_q[u_idx_q] + WAY_W'(1);
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d   = ST_CLEAR;
          set_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        valid_d[set_cnt_q] = '0;
        vptr_d[set_cnt_q]  = '0;
        if (flush)                                 set_cnt_d = '0;
        else if (set_cnt_q == IDX_W'(SET_NUM - 1)) state_d   = ST_IDLE;
        else                                       set_cnt_d = set_cnt_q + IDX_W'(1);
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      set_cnt_q <= '0;
      rdy_s_q   <= 1'b0;
      u_vld_q   <= 1'b0;
      lw_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      rdy_s_q   <= rdy_s_d;
      u_vld_q   <= u_vld_d;
      lw_vld_q  <= lw_vld_d;
    end
  end

  // Cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    valid_q    <= valid_d;
    vptr_q     <= vptr_d;
    rd_idx_s_q <= rd_idx_s_d;
    tag_s_q    <= tag_s_d;
    vld_s_q    <= vld_s_d;
    u_idx_q    <= u_idx_d;
    u_tag_q    <= u_tag_d;
    u_taken_q  <= u_taken_d;
    u_tgt_q    <= u_tgt_d;
    lw_idx_q   <= lw_idx_d;
    lw_way_q   <= lw_way_d;
    lw_data_q  <= lw_data_d;
  end

endmodule

// File: doc/assoc_btb.md
ASSOC_BTB -- requirements
Module: assoc_btb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC/target width in bits.
REQ-002 SHALL have parameter SET_NUM, default 64, number of sets; power of two, >=2.
REQ-003 SHALL have parameter WAY_NUM, default 2, ways per set; power of two, 1..8.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  one-cycle pulse that requests invalidation of all entries.
- ready  out  1  high when not invalidating.
- rdPc  in  ADDR_WIDTH  fetch PC to look up.
- btbHit  out  1  lookup hit with taken prediction, for the PC presented the previous cycle.
- btbPredictedPc  out  ADDR_WIDTH  predicted target, valid when btbHit is high.
- updValid  in  1  resolved branch update strobe.
- updPc  in  ADDR_WIDTH  PC of the resolved branch.
- updTaken  in  1  resolved direction.
- updTarget  in  ADDR_WIDTH  resolved target.

Function
REQ-005 SHALL treat PCs as word aligned: index = PC[2 +: log2(SET_NUM)]; tag = all PC bits above the index; target stored as PC[ADDR_WIDTH-1:2], with bits [1:0] restored as 0.
REQ-006 Each entry SHALL hold valid, tag, target and a 2-bit saturating counter; each set SHALL hold a round-robin victim pointer of log2(WAY_NUM) bits.
REQ-007 Lookup SHALL have 1-cycle latency: rdPc sampled at edge N drives btbHit/btbPredictedPc after edge N, held until the next edge.
REQ-008 btbHit SHALL be 1 only if ready was 1 at the sample edge, a valid way's tag matches, and that way's counter >= 2; btbPredictedPc SHALL then be that way's target, else 0.
REQ-009 A tag matching more than one way SHALL NOT occur; allocation on a tag match is forbidden by design.
REQ-010 Update on an updValid edge with ready=1, hit in way w: counter +1 if taken (saturate 3), -1 if not taken (saturate 0); target overwritten with updTarget only if taken.
REQ-011 Update miss with updTaken=1 SHALL allocate: lowest-numbered invalid way, else the way at the victim pointer; write valid=1, tag, target, counter=2; the victim pointer SHALL advance (mod WAY_NUM) only when no invalid way existed.
REQ-012 Update miss with updTaken=0 SHALL change no state.
REQ-013 A lookup and an update to the same set in the same cycle SHALL return the pre-update contents (read-before-write); the update is visible from the next lookup.
REQ-014 FSM states: IDLE and CLEAR. IDLE -> CLEAR on flush; CLEAR clears valid and resets the victim pointer of one set per cycle, using a set counter from 0 to SET_NUM-1; CLEAR -> IDLE after set SET_NUM-1. ready = (state == IDLE).
REQ-015 In CLEAR, btbHit SHALL be 0 and updates SHALL be dropped.
REQ-016 A flush in CLEAR SHALL restart the set counter at 0.
REQ-017 A flush and an updValid in the same IDLE cycle: flush wins and the update is dropped.

Reset
REQ-018 rst SHALL force state CLEAR, set counter 0, ready=0, btbHit=0, btbPredictedPc=0; the FSM then sweeps exactly as for flush, and ready rises SET_NUM cycles after rst deasserts.
REQ-019 rst asserted mid-sweep SHALL restart the sweep at set 0.
REQ-020 Tag, target and counter storage SHALL NOT need reset; only valid bits, victim pointers, FSM state, set counter and output registers are reset or cleared.

Structure
REQ-021 A shared package SHALL hold the entry struct (valid, tag, target, counter), the FSM state enum and the index/tag/target extraction functions parametrised by ADDR_WIDTH and SET_NUM.
REQ-022 Tag/target/counter arrays SHALL use one BlockDualPortRAM instance per way with registered read; valid bits and victim pointers SHALL be flops so the sweep and the invalid-way search are single-cycle.

Verification
REQ-023 Reset, SET_NUM=64: ready=0 for 64 cycles after rst falls, then 1; btbHit=0 throughout.
REQ-024 Update 0x1000 taken -> 0x2000; next cycle look up 0x1000 -> btbHit=1, btbPredictedPc=0x2000 one cycle later (counter=2).
REQ-025 Then update 0x1000 not taken -> lookup 0x1000 gives btbHit=0 (counter=1); update taken with target 0x3000 -> btbHit=1, btbPredictedPc=0x3000.
REQ-026 WAY_NUM=2, SET_NUM=64: taken updates to 0x0000, 0x0100, 0x0200 (same set 0) -> 0x0000 evicted; lookups give 0x0000 miss, 0x0100 hit, 0x0200 hit.
REQ-027 Lookup and update to 0x1000 taken -> 0x4000 in the same cycle on an empty BTB -> btbHit=0; the following lookup -> btbHit=1, btbPredictedPc=0x4000.
REQ-028 Populate entries, flush, re-flush at sweep cycle 10 -> ready low for 10+64 cycles, updates dropped, all lookups miss afterwards.
